// File: rtl/mux_2x1_32b_sync.sv
// Two-input word selector with combinational and registered outputs.
// Optional even-parity output enabled by MUX_2X1_32B_PARITY_EN.
module mux_2x1_32b_sync #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] Y,
  input  logic             Sel,
  input  logic [WIDTH-1:0] X0,
  input  logic [WIDTH-1:0] X1,
  output logic [WIDTH-1:0] Y_q,
  output logic             sel_q,
  output logic [CNT_W-1:0] chg_cnt
`ifdef MUX_2X1_32B_PARITY_EN
  ,
  output logic             Y_par
`endif
);

  logic [WIDTH-1:0] y_q;
  logic             sel_q_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Ternary merges X0/X1 bitwise when Sel is unknown.
  assign Y = Sel ? X1 : X0;

  always_comb begin
    cnt_d = cnt_q;
    if ((Sel != sel_q_q) && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q     <= '0;
      sel_q_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      y_q     <= Y;
      sel_q_q <= Sel;
      cnt_q   <= cnt_d;
    end
  end

  assign Y_q     = y_q;
  assign sel_q   = sel_q_q;
  assign chg_cnt = cnt_q;

`ifdef MUX_2X1_32B_PARITY_EN
  logic par_q;

  always_ff @(posedge clk) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= ^Y;
  end

  assign Y_par = par_q;
`endif

endmodule

// File: tb/tb_mux_2x1_32b_sync.sv
// Scoreboard bench for mux_2x1_32b_sync: random and directed stimulus,
// expected registered state queued by the driver, checked by a monitor.
module tb_mux_2x1_32b_sync;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] Y;
  logic        Sel;
  logic [31:0] X0;
  logic [31:0] X1;
  logic [31:0] Y_q;
  logic        sel_q;
  logic [15:0] chg_cnt;
`ifdef MUX_2X1_32B_PARITY_EN
  logic        Y_par;
`endif

  mux_2x1_32b_sync #(.WIDTH(32), .CNT_W(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .Y       (Y),
    .Sel     (Sel),
    .X0      (X0),
    .X1      (X1),
    .Y_q     (Y_q),
    .sel_q   (sel_q),
    .chg_cnt (chg_cnt)
`ifdef MUX_2X1_32B_PARITY_EN
    ,
    .Y_par   (Y_par)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] yq;
    logic        sq;
    logic [15:0] cnt;
    logic        par;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 0;

  // Reference model: state after the next edge.
  int   m_cnt = 0;
  bit   m_sel = 0;

  task automatic check32(string n, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, req);
    end
  endtask

  task automatic drive(bit rst, bit s, logic [31:0] a, logic [31:0] b,
                       string tag);
    exp_t e;
    logic [31:0] sel_word;
    rst_n = rst;
    Sel   = s;
    X0    = a;
    X1    = b;
    sel_word = s ? b : a;
    if (!rst) begin
      m_cnt = 0;
      m_sel = 0;
      e.yq  = 32'h0;
      e.par = 1'b0;
    end else begin
      if (s != m_sel && m_cnt < 65535) m_cnt++;
      m_sel = s;
      e.yq  = sel_word;
      e.par = ^sel_word;
    end
    e.sq  = m_sel;
    e.cnt = m_cnt[15:0];
    e.tag = tag;
    q.push_back(e);
    #1;
    check32({tag, ".Y"}, Y, sel_word);
    @(negedge clk);
  endtask

  // Monitor: compare registered outputs just after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check32({e.tag, ".Y_q"}, Y_q, e.yq);
        check32({e.tag, ".sel_q"}, {31'h0, sel_q}, {31'h0, e.sq});
        check32({e.tag, ".chg_cnt"}, {16'h0, chg_cnt}, {16'h0, e.cnt});
`ifdef MUX_2X1_32B_PARITY_EN
        check32({e.tag, ".Y_par"}, {31'h0, Y_par}, {31'h0, e.par});
`endif
      end
    end
  end

  initial begin
    int wait_cyc;
    drive(0, 0, 32'h0, 32'h1, "rst0");
    drive(0, 0, 32'h0, 32'h1, "rst1");
    drive(1, 0, 32'h0, 32'h1, "sel0");
    drive(1, 0, 32'h30, 32'h1, "x0chg");
    drive(1, 1, 32'h30, 32'h1, "sel01");
    drive(1, 1, 32'h30, 32'h0010_0000, "x1chg");
    drive(1, 1, 32'h30, 32'h0010_0000, "hold");
    drive(0, 1, 32'h30, 32'h0010_0000, "midrst");
    drive(1, 1, 32'h30, 32'h0010_0000, "release");
    drive(1, 0, 32'hFFFF_FFFF, 32'h0, "allones");
    drive(1, 1, 32'hFFFF_FFFF, 32'h0, "zeros");
    for (int i = 0; i < 300; i++) begin
      bit r;
      r = ($urandom_range(0, 19) != 0);
      drive(r, $urandom_range(0, 1) == 1, $urandom, $urandom, "rand");
    end
    drive(0, 0, 32'h0, 32'h0, "rst2");
    for (int i = 0; i < 66000; i++)
      drive(1, (i % 2) == 0, $urandom, $urandom, "toggle");
    drive(1, 1, 32'hA5A5_0F0F, 32'h1234_5678, "sat");
    drive(1, 0, 32'hA5A5_0F0F, 32'h1234_5678, "sat2");
    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    checks++;
    if (chg_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL final_sat: chg_cnt %h expected ffff", chg_cnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
